// File: rtl/vga_fade_stage.sv
// vga_fade_stage: 2-cycle video pipeline scaling RGB by a brightness level that ramps frame by frame.
// Sync is carried through the same two registers as colour so alignment is preserved.
module vga_fade_stage #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int STEP            = 1,
    parameter bit AUTO_FADE_IN    = 1'b1
) (
    input  logic       clk_vga,
    input  logic       reset,
    input  logic       in_hs,
    input  logic       in_vs,
    input  logic [5:0] in_r,
    input  logic [5:0] in_g,
    input  logic [5:0] in_b,
    input  logic       fade_in,
    input  logic       fade_out,
    output logic       out_hs,
    output logic       out_vs,
    output logic [5:0] out_r,
    output logic [5:0] out_g,
    output logic [5:0] out_b,
    output logic [5:0] level,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {BLACK, RAMP_UP, FULL, RAMP_DN} state_t;

    state_t     state_q, state_d;
    logic       s1_hs_q, s1_vs_q, s1_vs_d_q, auto_q, auto_d;
    logic [5:0] s1_r_q, s1_g_q, s1_b_q, level_d;
    logic [7:0] div_q, div_d;
    logic [6:0] up_lvl;
    logic       tick, go_up, go_dn, cmd, ramping, step_now, at_end, busy_d;

    function automatic logic [5:0] scale(input logic [5:0] c, input logic [5:0] l);
        return 6'(({6'd0, c} * {6'd0, l}) >> 5);
    endfunction

    always_comb begin
        tick     = s1_vs_q & ~s1_vs_d_q;
        go_up    = (fade_in & ~fade_out & (state_q == BLACK || state_q == RAMP_DN))
                 | (state_q == BLACK & auto_q & tick);
        go_dn    = fade_out & ~fade_in & (state_q == RAMP_UP || state_q == FULL);
        cmd      = go_up | go_dn;
        ramping  = state_q == RAMP_UP || state_q == RAMP_DN;
        // an accepted command in the same cycle as a tick suppresses the level update
        step_now = ramping & tick & ~cmd & (div_q + 8'd1 == 8'(FRAMES_PER_STEP));
        up_lvl   = 7'(level) + 7'(STEP);
        level_d  = !step_now ? level
                 : state_q == RAMP_UP ? (up_lvl >= 7'd32 ? 6'd32 : up_lvl[5:0])
                 : (7'(level) > 7'(STEP) ? 6'(7'(level) - 7'(STEP)) : 6'd0);
        at_end   = step_now & (level_d == 6'd0 || level_d == 6'd32);
        state_d  = go_up ? RAMP_UP : go_dn ? RAMP_DN
                 : at_end ? (state_q == RAMP_UP ? FULL : BLACK) : state_q;
        div_d    = (cmd || step_now || !ramping) ? 8'd0 : tick ? div_q + 8'd1 : div_q;
        auto_d   = auto_q & ~tick & ~cmd;
        busy_d   = state_d == RAMP_UP || state_d == RAMP_DN;
    end

    always_ff @(posedge clk_vga or posedge reset) begin
        if (reset) begin
            {s1_hs_q, s1_vs_q, s1_vs_d_q, s1_r_q, s1_g_q, s1_b_q} <= '0;
            {out_hs, out_vs, out_r, out_g, out_b} <= '0;
            state_q <= BLACK;
            level   <= '0;
            div_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            auto_q  <= AUTO_FADE_IN;
        end else begin
            {s1_hs_q, s1_vs_q, s1_r_q, s1_g_q, s1_b_q} <= {in_hs, in_vs, in_r, in_g, in_b};
            s1_vs_d_q <= s1_vs_q;
            out_hs  <= s1_hs_q;
            out_vs  <= s1_vs_q;
            out_r   <= scale(s1_r_q, level);
            out_g   <= scale(s1_g_q, level);
            out_b   <= scale(s1_b_q, level);
            state_q <= state_d;
            level   <= level_d;
            div_q   <= div_d;
            busy    <= busy_d;
            done    <= at_end;
            auto_q  <= auto_d;
        end
    end
endmodule

// File: tb/tb_vga_fade_stage.sv
// tb_vga_fade_stage: randomized frames and fade commands checked against a frame-level brightness model.
module tb_vga_fade_stage;
    localparam int FPS = 2;
    localparam int ST  = 5;
    localparam bit AUTO = 1'b1;

    logic clk_vga = 1'b0, reset = 1'b1, in_hs = 1'b0, in_vs = 1'b0, fade_in = 1'b0, fade_out = 1'b0;
    logic [5:0] in_r = '0, in_g = '0, in_b = '0;
    logic out_hs, out_vs, busy, done;
    logic [5:0] out_r, out_g, out_b, level;

    always #5 clk_vga = ~clk_vga;

    vga_fade_stage #(.FRAMES_PER_STEP(FPS), .STEP(ST), .AUTO_FADE_IN(AUTO)) dut (
        .clk_vga(clk_vga), .reset(reset), .in_hs(in_hs), .in_vs(in_vs),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .fade_in(fade_in), .fade_out(fade_out),
        .out_hs(out_hs), .out_vs(out_vs), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .level(level), .busy(busy), .done(done)
    );

    wire [27:0] got = {out_hs, out_vs, out_r, out_g, out_b, level, busy, done};

    int errors = 0, checks = 0;
    logic [27:0] exp_q[$];
    int lvl, dir, cnt, p_r, p_g, p_b, fpos = 0, flen = 8;
    bit auto_p, vs1, vs2, p_hs, p_vs;

    function automatic void model_reset();
        lvl = 0; dir = 0; cnt = 0; auto_p = AUTO;
        vs1 = 0; vs2 = 0; p_hs = 0; p_vs = 0; p_r = 0; p_g = 0; p_b = 0;
    endfunction

    // brightness is a number moving toward an endpoint; dir 0 means resting at 0 or 32
    task automatic model_edge();
        bit tick, fin, accepted;
        logic [27:0] e;
        tick = vs1 & ~vs2;
        fin = 0;
        accepted = 0;
        e[27] = p_hs;
        e[26] = p_vs;
        e[25:20] = 6'((p_r * lvl) / 32);
        e[19:14] = 6'((p_g * lvl) / 32);
        e[13:8]  = 6'((p_b * lvl) / 32);
        if (fade_in && !fade_out && dir != 1 && !(dir == 0 && lvl == 32)) begin
            dir = 1; accepted = 1;
        end else if (fade_out && !fade_in && dir != -1 && !(dir == 0 && lvl == 0)) begin
            dir = -1; accepted = 1;
        end else if (tick && dir == 0 && lvl == 0 && auto_p) begin
            dir = 1; accepted = 1;
        end else if (tick && dir != 0) begin
            cnt++;
            if (cnt == FPS) begin
                cnt = 0;
                lvl = dir > 0 ? (lvl + ST > 32 ? 32 : lvl + ST) : (lvl - ST < 0 ? 0 : lvl - ST);
                if (lvl == 0 || lvl == 32) begin dir = 0; fin = 1; end
            end
        end
        if (accepted) cnt = 0;
        if (accepted || tick) auto_p = 0;
        e[7:2] = 6'(lvl);
        e[1] = dir != 0;
        e[0] = fin;
        exp_q.push_back(e);
        p_hs = in_hs; p_vs = in_vs; p_r = in_r; p_g = in_g; p_b = in_b;
        vs2 = vs1; vs1 = in_vs;
    endtask

    task automatic cyc(input bit fi, input bit fo);
        in_hs = 1'($urandom);
        in_vs = fpos < 2;
        in_r = 6'($urandom); in_g = 6'($urandom); in_b = 6'($urandom);
        fade_in = fi;
        fade_out = fo;
        @(posedge clk_vga);
        model_edge();
        #1;
        fpos++;
        if (fpos >= flen) begin fpos = 0; flen = $urandom_range(6, 12); end
    endtask

    task automatic check_rest(input string name, input logic [5:0] want);
        checks++;
        if (level !== want || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s level=%0d busy=%b, required level=%0d busy=0", name, level, busy, want);
        end
    endtask

    always @(negedge clk_vga) begin
        if (exp_q.size() > 0) begin
            logic [27:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stream at %0t got=%h required=%h", $time, got, e);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_vga);
        @(negedge clk_vga) reset = 1'b0;
        repeat (250) cyc(0, 0);
        check_rest("auto_fade_full", 6'd32);
        cyc(0, 1);
        repeat (250) cyc(0, 0);
        check_rest("fade_out_black", 6'd0);
        repeat (2500) begin
            int r;
            r = $urandom_range(0, 99);
            cyc(r < 3 || r == 99, (r >= 3 && r < 6) || r == 99);
        end
        cyc(1, 0);
        repeat (250) cyc(0, 0);
        cyc(1, 1);
        repeat (30) cyc(0, 0);
        check_rest("both_cmds_in_full", 6'd32);
        cyc(0, 1);
        repeat (30) cyc(0, 0);
        @(negedge clk_vga);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (got !== 28'd0) begin
            errors++;
            $display("FAIL async_reset got=%h required=0", got);
        end
        @(posedge clk_vga);
        @(negedge clk_vga) reset = 1'b0;
        model_reset();
        repeat (250) cyc(0, 0);
        check_rest("auto_after_reset", 6'd32);
        @(negedge clk_vga);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
